// File: rtl/alu_operand_issue_if.sv
// Bundle of signals between the decode/issue stage and its neighbours.
// The slave modport is the issue stage's view; the master modport is the
// view of whatever drives instructions/writebacks and consumes bundles.
//
// Handshakes (both channels) use strict valid/ready semantics: a transfer
// happens on a rising clock edge where valid & ready are both 1; a producer
// never makes valid depend on ready, and once valid is raised the payload
// stays stable until the transfer happens. Ready may depend combinationally
// on the payload (in_ready looks at in_instr and the wb_* port).
interface alu_operand_issue_if;
    // Instruction input channel
    logic        in_valid;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic        in_ready;
    // Registered operand bundle towards the ALU stage
    logic [4:0]  OpCode;
    logic [1:0]  funct;
    logic [15:0] Rs;
    logic [15:0] Rt;
    logic [15:0] Pc;
    logic [7:0]  Imm;
    logic [2:0]  dst_reg;
    logic        dst_en;
    logic        out_valid;
    logic        out_ready;
    // Writeback port (no handshake, strobe only)
    logic        wb_en;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;
    // Status / debug visibility
    logic        halted;
    logic [7:0]  pend;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready, wb_en, wb_reg, wb_data,
        output in_ready, OpCode, funct, Rs, Rt, Pc, Imm, dst_reg, dst_en,
               out_valid, halted, pend
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready, wb_en, wb_reg, wb_data,
        input  in_ready, OpCode, funct, Rs, Rt, Pc, Imm, dst_reg, dst_en,
               out_valid, halted, pend
    );
endinterface

// File: rtl/alu_operand_issue.sv
// Decode/issue stage in front of the ALU. Decodes a 16-bit WISC instruction,
// reads its two source registers from a local 8x16 register file (with a
// bypass from the same-cycle writeback), blocks RAW/WAW hazards through a
// pending-write scoreboard, and hands one registered operand bundle per
// instruction to the ALU stage. HALT stops further issue until reset.
module alu_operand_issue #(
    parameter int NREG  = 8,
    parameter int WIDTH = 16
) (
    input logic               clk,
    input logic               rst_n,
    alu_operand_issue_if.slave bus
);

    // Run/halt control. The current state is visible on bus.halted.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t state_q, state_d;

    // ------------------------------------------------------------------
    // Instruction field extraction
    // ------------------------------------------------------------------
    logic [4:0] opcode;
    logic [2:0] rs_idx;
    logic [2:0] rt_idx;

    assign opcode = bus.in_instr[15:11];
    assign rs_idx = bus.in_instr[10:8];
    assign rt_idx = bus.in_instr[7:5];

    // ------------------------------------------------------------------
    // Decode: destination register and which sources are really read
    // ------------------------------------------------------------------
    logic       dec_dst_en;
    logic [2:0] dec_dst;
    logic       dec_rs_used;
    logic       dec_rt_used;
    logic       dec_is_halt;

    // Destination selection and Rt usage per opcode group.
    always_comb begin
        dec_dst_en  = 1'b0;
        dec_dst     = 3'd0;
        dec_rt_used = 1'b0;
        casez (opcode)
            // Three-register ALU/compare forms write instr[4:2] and read Rt.
            5'b11011, 5'b11010, 5'b111??: begin
                dec_dst_en  = 1'b1;
                dec_dst     = bus.in_instr[4:2];
                dec_rt_used = 1'b1;
            end
            // btr only bit-reverses Rs; its Rt field is ignored.
            5'b11001: begin
                dec_dst_en = 1'b1;
                dec_dst    = bus.in_instr[4:2];
            end
            // Immediate ALU/shift forms and ld write instr[7:5].
            5'b010??, 5'b101??, 5'b10001: begin
                dec_dst_en = 1'b1;
                dec_dst    = bus.in_instr[7:5];
            end
            // stu writes the updated base back into Rs and stores Rt.
            5'b10011: begin
                dec_dst_en  = 1'b1;
                dec_dst     = bus.in_instr[10:8];
                dec_rt_used = 1'b1;
            end
            // lbi / slbi write instr[10:8].
            5'b11000, 5'b10010: begin
                dec_dst_en = 1'b1;
                dec_dst    = bus.in_instr[10:8];
            end
            // jal / jalr write the link register r7.
            5'b00110, 5'b00111: begin
                dec_dst_en = 1'b1;
                dec_dst    = 3'd7;
            end
            // st reads Rt as the store data but writes nothing.
            5'b10000: begin
                dec_rt_used = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Rs is read by everything except lbi, halt, nop, j and jal.
    always_comb begin
        dec_rs_used = 1'b1;
        case (opcode)
            5'b11000, 5'b00000, 5'b00001, 5'b00100, 5'b00110: dec_rs_used = 1'b0;
            default: dec_rs_used = 1'b1;
        endcase
    end

    assign dec_is_halt = (opcode == 5'b00000);

    // ------------------------------------------------------------------
    // Register file with same-cycle writeback bypass on the read side
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] rf_q [NREG];
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             wb_hit_rs;
    logic             wb_hit_rt;
    logic             wb_hit_dst;

    assign wb_hit_rs  = bus.wb_en && (bus.wb_reg == rs_idx);
    assign wb_hit_rt  = bus.wb_en && (bus.wb_reg == rt_idx);
    assign wb_hit_dst = bus.wb_en && (bus.wb_reg == dec_dst);

    assign rs_val = wb_hit_rs ? bus.wb_data : rf_q[rs_idx];
    assign rt_val = wb_hit_rt ? bus.wb_data : rf_q[rt_idx];

    // Writeback stores unconditionally on wb_en; r0 is an ordinary register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (bus.wb_en) begin
            rf_q[bus.wb_reg] <= bus.wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard and hazard detection
    // ------------------------------------------------------------------
    logic [NREG-1:0] pend_q, pend_d;
    logic            rs_hazard;
    logic            rt_hazard;
    logic            dst_hazard;
    logic            hazard;

    // A writeback landing this cycle resolves the hazard because its value
    // is bypassed into the read (RAW) and it completes before ours (WAW).
    assign rs_hazard  = dec_rs_used && pend_q[rs_idx]  && !wb_hit_rs;
    assign rt_hazard  = dec_rt_used && pend_q[rt_idx]  && !wb_hit_rt;
    assign dst_hazard = dec_dst_en  && pend_q[dec_dst] && !wb_hit_dst;
    assign hazard     = rs_hazard || rt_hazard || dst_hazard;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic out_valid_q, out_valid_d;
    logic accept;

    assign bus.in_ready = rst_n && (state_q == ST_RUN) && !hazard &&
                          (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // Clear on writeback first, then set on accept so that a same-cycle
    // set and clear of one register leaves it pending.
    always_comb begin
        pend_d = pend_q;
        if (bus.wb_en) begin
            pend_d[bus.wb_reg] = 1'b0;
        end
        if (accept && dec_dst_en) begin
            pend_d[dec_dst] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Run/halt control
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: issuing HALT parks the stage until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (accept && dec_is_halt) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output bundle register
    // ------------------------------------------------------------------
    logic [4:0]       opcode_q;
    logic [1:0]       funct_q;
    logic [WIDTH-1:0] rs_q;
    logic [WIDTH-1:0] rt_q;
    logic [15:0]      pc_q;
    logic [7:0]       imm_q;
    logic [2:0]       dst_reg_q;
    logic             dst_en_q;

    // Valid holds while the ALU stage stalls; a new accept replaces the
    // bundle even in the cycle the previous one is consumed.
    assign out_valid_d = accept || (out_valid_q && !bus.out_ready);

    // Bundle capture on accept; otherwise the bundle holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            opcode_q    <= '0;
            funct_q     <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            pc_q        <= '0;
            imm_q       <= '0;
            dst_reg_q   <= '0;
            dst_en_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (accept) begin
                opcode_q  <= opcode;
                funct_q   <= bus.in_instr[1:0];
                rs_q      <= rs_val;
                rt_q      <= rt_val;
                pc_q      <= bus.in_pc;
                imm_q     <= bus.in_instr[7:0];
                dst_reg_q <= dec_dst;
                dst_en_q  <= dec_dst_en;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.OpCode    = opcode_q;
    assign bus.funct     = funct_q;
    assign bus.Rs        = rs_q;
    assign bus.Rt        = rt_q;
    assign bus.Pc        = pc_q;
    assign bus.Imm       = imm_q;
    assign bus.dst_reg   = dst_reg_q;
    assign bus.dst_en    = dst_en_q;
    assign bus.halted    = (state_q == ST_HALT);
    assign bus.pend      = pend_q;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Bench for alu_operand_issue: directed scenarios followed by random traffic,
// all checked cycle by cycle against an opcode-table reference model.
module tb_alu_operand_issue;
  localparam int W = 67;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_operand_issue_if bus();

  alu_operand_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- reference model state ----------------
  logic [15:0]  m_rf [8];
  bit           m_pend [8];
  bit           m_halt;
  logic [W-1:0] exp_q [$];
  int           n_checks = 0;
  int           n_errors = 0;
  logic         seen_ready;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Architectural meaning of each opcode (decimal opcode numbers).
  function automatic void ref_decode(input logic [15:0] ins, output bit wr,
                                     output logic [2:0] d, output bit use_s, output bit use_t);
    int op;
    op = int'(ins[15:11]);
    wr = 1'b1;
    d  = 3'd0;
    if (op == 27 || op == 26 || op == 25 || op >= 28) d = ins[4:2];
    else if ((op >= 8 && op <= 11) || (op >= 20 && op <= 23) || op == 17) d = ins[7:5];
    else if (op == 19 || op == 24 || op == 18) d = ins[10:8];
    else if (op == 6 || op == 7) d = 3'd7;
    else wr = 1'b0;
    use_s = !(op == 24 || op == 0 || op == 1 || op == 4 || op == 6);
    use_t = (op == 27 || op == 26 || op >= 28 || op == 16 || op == 19);
  endfunction

  function automatic bit wb_hits(input logic [2:0] r);
    return bus.wb_en && (bus.wb_reg == r);
  endfunction

  function automatic logic [15:0] m_read(input logic [2:0] r);
    return wb_hits(r) ? bus.wb_data : m_rf[r];
  endfunction

  function automatic logic [7:0] m_pend_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic logic [W-1:0] dut_bundle();
    return {bus.OpCode, bus.funct, bus.Rs, bus.Rt, bus.Pc, bus.Imm, bus.dst_reg, bus.dst_en};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_rf[i] = 16'h0000;
      m_pend[i] = 1'b0;
    end
    m_halt = 1'b0;
    exp_q.delete();
  endtask

  // Evaluated at the falling edge, with inputs stable until the next rising edge.
  task automatic eval_cycle();
    bit wr, us, ut, hz, rdy, acc;
    logic [2:0] d, rs, rt;
    logic [W-1:0] b;
    ref_decode(bus.in_instr, wr, d, us, ut);
    rs = bus.in_instr[10:8];
    rt = bus.in_instr[7:5];
    hz = (us && m_pend[rs] && !wb_hits(rs)) ||
         (ut && m_pend[rt] && !wb_hits(rt)) ||
         (wr && m_pend[d]  && !wb_hits(d));
    rdy = !m_halt && !hz && (exp_q.size() == 0 || bus.out_ready);
    seen_ready = bus.in_ready;
    check("in_ready", W'(bus.in_ready), W'(rdy));
    check("out_valid", W'(bus.out_valid), W'(exp_q.size() != 0));
    check("halted", W'(bus.halted), W'(m_halt));
    check("pend", W'(bus.pend), W'(m_pend_vec()));
    if (bus.out_valid && exp_q.size() != 0) check("bundle", dut_bundle(), exp_q[0]);
    acc = bus.in_valid && rdy;
    b = {bus.in_instr[15:11], bus.in_instr[1:0], m_read(rs), m_read(rt), bus.in_pc,
         bus.in_instr[7:0], d, wr};
    if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(b);
    if (bus.wb_en) begin
      m_rf[bus.wb_reg] = bus.wb_data;
      m_pend[bus.wb_reg] = 1'b0;
    end
    if (acc && wr) m_pend[d] = 1'b1;
    if (acc && bus.in_instr[15:11] == 5'b00000) m_halt = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  // Caller sets inputs just after a rising edge; returns 1 time unit after the next one.
  task automatic step();
    @(negedge clk);
    eval_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [15:0] ins, input logic [15:0] pc);
    bus.in_valid = v;
    bus.in_instr = ins;
    bus.in_pc    = pc;
  endtask

  task automatic drive_wb(input logic en, input logic [2:0] r, input logic [15:0] data);
    bus.wb_en   = en;
    bus.wb_reg  = r;
    bus.wb_data = data;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, W'(bus.out_valid), W'(0));
    check({tag, "_in_ready"}, W'(bus.in_ready), W'(0));
    check({tag, "_halted"}, W'(bus.halted), W'(0));
    check({tag, "_pend"}, W'(bus.pend), W'(0));
    check({tag, "_bundle"}, dut_bundle(), W'(0));
  endtask

  task automatic random_cycle();
    logic [15:0] ins;
    int np;
    logic [2:0] plist [8];
    ins = 16'($urandom_range(0, 65535));
    if (ins[15:11] == 5'b00000) ins[15:11] = 5'b00001;
    drive_in(1'($urandom_range(0, 9) < 7), ins, 16'($urandom_range(0, 65535)));
    bus.out_ready = 1'($urandom_range(0, 9) < 7);
    np = 0;
    for (int i = 0; i < 8; i++) if (m_pend[i]) begin plist[np] = 3'(i); np++; end
    if ($urandom_range(0, 9) < 4) begin
      if (np > 0 && $urandom_range(0, 1) == 1)
        drive_wb(1'b1, plist[$urandom_range(0, np - 1)], 16'($urandom_range(0, 65535)));
      else
        drive_wb(1'b1, 3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)));
    end else begin
      drive_wb(1'b0, 3'd0, 16'h0000);
    end
    step();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    drive_in(1'b0, 16'h0000, 16'h0000);
    drive_wb(1'b0, 3'd0, 16'h0000);
    bus.out_ready = 1'b0;
    model_clear();
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("init_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: writeback r2, then issue 4225 and look at the bundle.
    drive_wb(1'b1, 3'd2, 16'h0010);
    step();
    drive_wb(1'b0, 3'd0, 16'h0000);
    drive_in(1'b1, 16'h4225, 16'h0102);
    step();
    drive_in(1'b0, 16'h0000, 16'h0000);
    check("t1_out_valid", W'(bus.out_valid), W'(1));
    check("t1_opcode", W'(bus.OpCode), W'(5'b01000));
    check("t1_rs", W'(bus.Rs), W'(16'h0010));
    check("t1_imm", W'(bus.Imm), W'(8'h25));
    check("t1_dst", W'({bus.dst_reg, bus.dst_en}), W'({3'd1, 1'b1}));
    bus.out_ready = 1'b1;
    step();

    // 2: lbi r3, then add r4=r3+r1 held until both writebacks land.
    drive_in(1'b1, 16'hC37F, 16'h0104);
    step();
    drive_in(1'b1, 16'hDB30, 16'h0106);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_held", W'(seen_ready), W'(0));
    end
    drive_wb(1'b1, 3'd3, 16'h007F);
    step();
    check("t2_held_after_r3", W'(seen_ready), W'(0));
    drive_wb(1'b1, 3'd1, 16'h0015);
    step();
    check("t2_accept_on_r1_wb", W'(seen_ready), W'(1));
    drive_wb(1'b0, 3'd0, 16'h0000);
    drive_in(1'b0, 16'h0000, 16'h0000);
    bus.out_ready = 1'b0;
    step();
    check("t2_rs_fwd", W'({bus.Rs, bus.Rt}), W'({16'h007F, 16'h0015}));

    // 3: stall five cycles with a hazard-free instruction waiting, then release.
    drive_in(1'b1, 16'h4000, 16'h0108);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_stall_ready", W'(seen_ready), W'(0));
      check("t3_stall_rs", W'(bus.Rs), W'(16'h007F));
    end
    bus.out_ready = 1'b1;
    step();
    check("t3_b2b_ready", W'(seen_ready), W'(1));
    check("t3_b2b_valid", W'({bus.out_valid, bus.Pc}), W'({1'b1, 16'h0108}));
    drive_in(1'b0, 16'h0000, 16'h0000);
    step();

    // 4: accept dst r1 in the same cycle r1 is written back: stays pending.
    drive_in(1'b1, 16'h4225, 16'h010A);
    step();
    drive_wb(1'b1, 3'd1, 16'h0055);
    step();
    check("t4_accept", W'(seen_ready), W'(1));
    check("t4_pend1", W'(bus.pend[1]), W'(1));
    drive_wb(1'b0, 3'd0, 16'h0000);
    drive_in(1'b0, 16'h0000, 16'h0000);
    step();

    // Random traffic.
    for (int i = 0; i < 1500; i++) random_cycle();

    // 6: drain, stall with a pending lbi, then reset mid-stall.
    drive_in(1'b0, 16'h0000, 16'h0000);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_wb(1'b1, 3'(i), 16'(16'h1000 + i));
      step();
    end
    drive_wb(1'b0, 3'd0, 16'h0000);
    bus.out_ready = 1'b0;
    drive_in(1'b1, 16'hC37F, 16'h0200);
    step();
    drive_in(1'b1, 16'h4225, 16'h0202);
    step();
    step();
    check("t6_pend3", W'(bus.pend[3]), W'(1));
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("t6_rst");
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive_in(1'b1, 16'hDB30, 16'h0204);
    step();
    check("t6_post_accept", W'(seen_ready), W'(1));
    check("t6_regs_zero", W'({bus.Rs, bus.Rt}), W'(0));
    drive_in(1'b0, 16'h0000, 16'h0000);
    step();

    // 5: HALT issues, then nothing more is accepted; writeback still works.
    drive_in(1'b1, 16'h0000, 16'h0206);
    step();
    check("t5_halt_accept", W'(seen_ready), W'(1));
    check("t5_halted", W'(bus.halted), W'(1));
    drive_in(1'b1, 16'h4225, 16'h0208);
    for (int i = 0; i < 10; i++) begin
      drive_wb(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)));
      step();
      check("t5_halt_ready", W'(seen_ready), W'(0));
    end
    drive_in(1'b0, 16'h0000, 16'h0000);
    drive_wb(1'b0, 3'd0, 16'h0000);
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
